// File: rtl/smart_mac_router.sv
// Multi-lane smart-bus MAC processing element: signed MAC, systolic pass-through,
// lane-selectable operands and saturated result insertion. Define SMART_BUS_PIPE_EN to register bus outputs.

module smart_mac_lane #(
  parameter int W      = 16,
  parameter int LIDX_W = 1,
  parameter int IDX    = 0
) (
  input  logic [W:0]        lane_in,
  input  logic              ins_en,
  input  logic [LIDX_W-1:0] ins_lane,
  input  logic [W:0]        ins_word,
  output logic [W:0]        lane_out
);
  // An out-of-range lane index matches no instance, so every lane passes through.
  assign lane_out = (ins_en && ins_lane == LIDX_W'(IDX)) ? ins_word : lane_in;
endmodule

module smart_mac_router #(
  parameter int WORD_SIZE = 16,
  parameter int LANES     = 2,
  parameter int ACC_SIZE  = 40,
  parameter int CNT_W     = 8,
  localparam int SEL_W    = $clog2(LANES + 1),
  localparam int LIDX_W   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int LW       = WORD_SIZE + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load_in,
  input  logic [SEL_W-1:0]      cfg_src_left_in,
  input  logic [SEL_W-1:0]      cfg_src_top_in,
  input  logic                  cfg_h_ins_en_in,
  input  logic [LIDX_W-1:0]     cfg_h_ins_lane_in,
  input  logic                  cfg_v_ins_en_in,
  input  logic [LIDX_W-1:0]     cfg_v_ins_lane_in,
  input  logic [CNT_W-1:0]      cfg_acc_len_in,
  output logic                  cfg_busy_out,
  input  logic [WORD_SIZE-1:0]  left_in,
  input  logic                  left_valid_in,
  input  logic [WORD_SIZE-1:0]  top_in,
  input  logic                  top_valid_in,
  output logic [WORD_SIZE-1:0]  right_out,
  output logic                  right_valid_out,
  output logic [WORD_SIZE-1:0]  bottom_out,
  output logic                  bottom_valid_out,
  input  logic [LANES*LW-1:0]   horizontal_smart_bus_in,
  output logic [LANES*LW-1:0]   horizontal_smart_bus_out,
  input  logic [LANES*LW-1:0]   vertical_smart_bus_in,
  output logic [LANES*LW-1:0]   vertical_smart_bus_out,
  output logic [ACC_SIZE-1:0]   result_out,
  output logic                  result_valid_out
);

  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] data;
  } lane_t;

  typedef struct packed {
    logic [SEL_W-1:0]  src_left;
    logic [SEL_W-1:0]  src_top;
    logic              h_en;
    logic [LIDX_W-1:0] h_lane;
    logic              v_en;
    logic [LIDX_W-1:0] v_lane;
    logic [CNT_W-1:0]  acc_len;
  } cfg_t;

  typedef enum logic {IDLE, ACC} state_t;

  localparam cfg_t CFG_RST = '{src_left: '0, src_top: '0, h_en: 1'b0, h_lane: '0,
                               v_en: 1'b0, v_lane: '0, acc_len: CNT_W'(1)};
  localparam logic signed [ACC_SIZE-1:0] SMAX =
    {{(ACC_SIZE-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] SMIN =
    {{(ACC_SIZE-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  cfg_t   cfg, cfg_nxt, cfg_new;
  state_t state, state_nxt;
  logic [ACC_SIZE-1:0] acc, acc_nxt, res_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, eff_len;
  logic                rv_nxt;

  lane_t [LANES-1:0] h_lane_in, v_lane_in;
  lane_t a, b;
  logic  fire;
  logic signed [2*WORD_SIZE-1:0] mul;
  logic signed [ACC_SIZE-1:0]    prod;

  // ---------------- operand selection ----------------
  assign h_lane_in = horizontal_smart_bus_in;
  assign v_lane_in = vertical_smart_bus_in;

  always_comb begin
    a = '{valid: left_valid_in, data: left_in};
    b = '{valid: top_valid_in,  data: top_in};
    for (int k = 0; k < LANES; k++) begin
      if (cfg.src_left == SEL_W'(k + 1)) a = h_lane_in[k];
      if (cfg.src_top  == SEL_W'(k + 1)) b = v_lane_in[k];
    end
  end

  assign fire    = a.valid & b.valid;
  assign mul     = $signed(a.data) * $signed(b.data);
  assign prod    = ACC_SIZE'(mul);
  assign eff_len = (cfg.acc_len == '0) ? CNT_W'(1) : cfg.acc_len;

  assign cfg_new = '{src_left: cfg_src_left_in, src_top: cfg_src_top_in,
                     h_en: cfg_h_ins_en_in, h_lane: cfg_h_ins_lane_in,
                     v_en: cfg_v_ins_en_in, v_lane: cfg_v_ins_lane_in,
                     acc_len: cfg_acc_len_in};

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cfg              <= CFG_RST;
      acc              <= '0;
      cnt              <= '0;
      result_out       <= '0;
      result_valid_out <= 1'b0;
      right_out        <= '0;
      right_valid_out  <= 1'b0;
      bottom_out       <= '0;
      bottom_valid_out <= 1'b0;
    end else begin
      state            <= state_nxt;
      cfg              <= cfg_nxt;
      acc              <= acc_nxt;
      cnt              <= cnt_nxt;
      result_out       <= res_nxt;
      result_valid_out <= rv_nxt;
      right_out        <= a.data;
      right_valid_out  <= a.valid;
      bottom_out       <= b.data;
      bottom_valid_out <= b.valid;
    end
  end

  always_comb begin
    state_nxt    = state;
    cfg_nxt      = cfg;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    res_nxt      = result_out;
    rv_nxt       = 1'b0;
    cfg_busy_out = 1'b0;
    case (state)
      IDLE: begin
        // A same-cycle fire still sees the old config through eff_len.
        if (cfg_load_in) cfg_nxt = cfg_new;
        if (fire) begin
          if (eff_len == CNT_W'(1)) begin
            res_nxt = prod;
            rv_nxt  = 1'b1;
          end else begin
            acc_nxt   = prod;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        cfg_busy_out = 1'b1;
        if (fire) begin
          if (cnt + CNT_W'(1) == eff_len) begin
            res_nxt   = acc + prod;
            rv_nxt    = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            acc_nxt = acc + prod;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- bus insertion ----------------
  logic [WORD_SIZE-1:0] sat;
  logic [LW-1:0]        ins_word;
  logic [LANES*LW-1:0]  h_nxt, v_nxt;

  always_comb begin
    if ($signed(result_out) > SMAX)      sat = {1'b0, {(WORD_SIZE-1){1'b1}}};
    else if ($signed(result_out) < SMIN) sat = {1'b1, {(WORD_SIZE-1){1'b0}}};
    else                                 sat = result_out[WORD_SIZE-1:0];
  end

  assign ins_word = {result_valid_out, sat};

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    smart_mac_lane #(.W(WORD_SIZE), .LIDX_W(LIDX_W), .IDX(k)) u_h (
      .lane_in  (horizontal_smart_bus_in[k*LW +: LW]),
      .ins_en   (cfg.h_en),
      .ins_lane (cfg.h_lane),
      .ins_word (ins_word),
      .lane_out (h_nxt[k*LW +: LW])
    );
    smart_mac_lane #(.W(WORD_SIZE), .LIDX_W(LIDX_W), .IDX(k)) u_v (
      .lane_in  (vertical_smart_bus_in[k*LW +: LW]),
      .ins_en   (cfg.v_en),
      .ins_lane (cfg.v_lane),
      .ins_word (ins_word),
      .lane_out (v_nxt[k*LW +: LW])
    );
  end

`ifdef SMART_BUS_PIPE_EN
  logic [LANES*LW-1:0] h_q, v_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_nxt;
      v_q <= v_nxt;
    end
  end
  assign horizontal_smart_bus_out = h_q;
  assign vertical_smart_bus_out   = v_q;
`else
  assign horizontal_smart_bus_out = h_nxt;
  assign vertical_smart_bus_out   = v_nxt;
`endif

endmodule

// File: tb/tb_smart_mac_router.sv
// Scoreboard bench for smart_mac_router: expected results are queued as stimulus is driven
// and popped by a monitor on each result pulse; directed checks cover routing and bus insertion.

module tb_smart_mac_router;
  localparam int WORD_SIZE = 16;
  localparam int LANES     = 2;
  localparam int ACC_SIZE  = 40;
  localparam int CNT_W     = 8;
  localparam int SEL_W     = $clog2(LANES + 1);
  localparam int LIDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LW        = WORD_SIZE + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic                 cfg_load_in = 1'b0;
  logic [SEL_W-1:0]     cfg_src_left_in = '0, cfg_src_top_in = '0;
  logic                 cfg_h_ins_en_in = 1'b0, cfg_v_ins_en_in = 1'b0;
  logic [LIDX_W-1:0]    cfg_h_ins_lane_in = '0, cfg_v_ins_lane_in = '0;
  logic [CNT_W-1:0]     cfg_acc_len_in = '0;
  logic                 cfg_busy_out;
  logic [WORD_SIZE-1:0] left_in = '0, top_in = '0;
  logic                 left_valid_in = 1'b0, top_valid_in = 1'b0;
  logic [WORD_SIZE-1:0] right_out, bottom_out;
  logic                 right_valid_out, bottom_valid_out;
  logic [LANES*LW-1:0]  h_in = '0, v_in = '0, h_out, v_out;
  logic [ACC_SIZE-1:0]  result_out;
  logic                 result_valid_out;

  smart_mac_router #(.WORD_SIZE(WORD_SIZE), .LANES(LANES), .ACC_SIZE(ACC_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_load_in(cfg_load_in), .cfg_src_left_in(cfg_src_left_in), .cfg_src_top_in(cfg_src_top_in),
    .cfg_h_ins_en_in(cfg_h_ins_en_in), .cfg_h_ins_lane_in(cfg_h_ins_lane_in),
    .cfg_v_ins_en_in(cfg_v_ins_en_in), .cfg_v_ins_lane_in(cfg_v_ins_lane_in),
    .cfg_acc_len_in(cfg_acc_len_in), .cfg_busy_out(cfg_busy_out),
    .left_in(left_in), .left_valid_in(left_valid_in), .top_in(top_in), .top_valid_in(top_valid_in),
    .right_out(right_out), .right_valid_out(right_valid_out),
    .bottom_out(bottom_out), .bottom_valid_out(bottom_valid_out),
    .horizontal_smart_bus_in(h_in), .horizontal_smart_bus_out(h_out),
    .vertical_smart_bus_in(v_in), .vertical_smart_bus_out(v_out),
    .result_out(result_out), .result_valid_out(result_valid_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [ACC_SIZE-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && result_valid_out) begin
      if (exp_q.size() == 0) chk("spurious_pulse", 64'(result_out), 64'hDEAD);
      else chk("result", 64'(result_out), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
`ifdef SMART_BUS_PIPE_EN
    cyc();
`endif
  endtask

  task automatic push(input longint v);
    exp_q.push_back(ACC_SIZE'(v));
  endtask

  task automatic cfg(input int sl, input int st, input logic he, input int hl,
                     input logic ve, input int vl, input int len);
    cfg_src_left_in   = SEL_W'(sl);
    cfg_src_top_in    = SEL_W'(st);
    cfg_h_ins_en_in   = he;
    cfg_h_ins_lane_in = LIDX_W'(hl);
    cfg_v_ins_en_in   = ve;
    cfg_v_ins_lane_in = LIDX_W'(vl);
    cfg_acc_len_in    = CNT_W'(len);
    cfg_load_in       = 1'b1;
    cyc();
    cfg_load_in       = 1'b0;
  endtask

  task automatic op(input int l, input logic lv, input int t, input logic tv);
    left_in = WORD_SIZE'(l); left_valid_in = lv;
    top_in  = WORD_SIZE'(t); top_valid_in  = tv;
    cyc();
    left_valid_in = 1'b0; top_valid_in = 1'b0;
  endtask

  initial begin
    longint sum;
    int ra, rb;

    // reset state
    cyc(); cyc();
    chk("rst_result", 64'(result_out), 64'd0);
    chk("rst_rvalid", 64'(result_valid_out), 64'd0);
    chk("rst_right_v", 64'(right_valid_out), 64'd0);
    chk("rst_busy", 64'(cfg_busy_out), 64'd0);
    rst = 1'b1;
    cyc();

    // single product, local operands
    cfg(0, 0, 0, 0, 0, 0, 1);
    push(-12);
    op(3, 1, -4, 1);
    chk("t1_rvalid", 64'(result_valid_out), 64'd1);
    chk("t1_right", 64'(right_out), 64'd3);
    chk("t1_bottom", 64'(bottom_out), 64'hFFFC);
    cyc();
    chk("t1_pulse_end", 64'(result_valid_out), 64'd0);

    // length-3 reduction with a gap and an ignored cfg load
    cfg(0, 0, 0, 0, 0, 0, 3);
    push(5);
    op(2, 1, 5, 1);
    chk("t2_busy1", 64'(cfg_busy_out), 64'd1);
    cfg_acc_len_in = CNT_W'(1); cfg_load_in = 1'b1;
    cyc();
    cfg_load_in = 1'b0;
    chk("t2_busy_gap", 64'(cfg_busy_out), 64'd1);
    op(1, 1, 1, 1);
    chk("t2_no_early", 64'(result_valid_out), 64'd0);
    op(-3, 1, 2, 1);
    chk("t2_rvalid", 64'(result_valid_out), 64'd1);
    chk("t2_idle", 64'(cfg_busy_out), 64'd0);
    push(7);
    op(7, 1, 1, 1);
    chk("t2_len_kept", 64'(cfg_busy_out), 64'd1);
    op(0, 1, 0, 1);
    op(0, 1, 0, 1);
    chk("t2b_rvalid", 64'(result_valid_out), 64'd1);

    // operands from bus lanes
    cfg(2, 1, 0, 0, 0, 0, 1);
    h_in[1*LW +: LW] = {1'b1, 16'd7};
    v_in[0*LW +: LW] = {1'b1, 16'd6};
    push(42);
    op(0, 0, 0, 0);
    chk("t3_right", 64'(right_out), 64'd7);
    chk("t3_right_v", 64'(right_valid_out), 64'd1);
    chk("t3_bottom", 64'(bottom_out), 64'd6);
    h_in = '0; v_in = '0;
    cyc();

    // saturated insertion on h-lane 0
    cfg(0, 0, 1, 0, 0, 0, 1);
    h_in[0*LW +: LW] = {1'b1, 16'h5555};
    h_in[1*LW +: LW] = {1'b1, 16'h1234};
    v_in[0*LW +: LW] = {1'b1, 16'h0BEE};
    push(90000);
    op(300, 1, 300, 1);
    settle();
    chk("t4_ins_pos", 64'(h_out[0*LW +: LW]), 64'h1_7FFF);
    chk("t4_h_pass", 64'(h_out[1*LW +: LW]), 64'h1_1234);
    chk("t4_v_pass", 64'(v_out[0*LW +: LW]), 64'h1_0BEE);
    cyc();
    chk("t4_ins_drop", 64'(h_out[0*LW +: LW]), 64'h0_7FFF);
    push(-90000);
    op(-300, 1, 300, 1);
    settle();
    chk("t4_ins_neg", 64'(h_out[0*LW +: LW]), 64'h1_8000);

    // hop latency of a passing lane
    h_in[1*LW +: LW] = {1'b1, 16'h0ABC};
    #1;
`ifdef SMART_BUS_PIPE_EN
    chk("t6_hop_old", 64'(h_out[1*LW +: LW]), 64'h1_1234);
`else
    chk("t6_hop_now", 64'(h_out[1*LW +: LW]), 64'h1_0ABC);
`endif
    cyc();
    chk("t6_hop_new", 64'(h_out[1*LW +: LW]), 64'h1_0ABC);
    h_in = '0; v_in = '0;
    cyc();

    // reset mid-accumulation discards the partial sum
    cfg(0, 0, 0, 0, 0, 0, 4);
    op(5, 1, 5, 1);
    op(5, 1, 5, 1);
    rst = 1'b0;
    cyc();
    chk("t5_busy_rst", 64'(cfg_busy_out), 64'd0);
    chk("t5_result_rst", 64'(result_out), 64'd0);
    rst = 1'b1;
    cfg(0, 0, 0, 0, 0, 0, 4);
    push(4);
    for (int i = 0; i < 4; i++) op(1, 1, 1, 1);
    chk("t5_rvalid", 64'(result_valid_out), 64'd1);

    // random length-4 reductions against a running sum
    for (int r = 0; r < 3; r++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        ra = int'($urandom_range(2000)) - 1000;
        rb = int'($urandom_range(2000)) - 1000;
        sum += longint'(ra) * longint'(rb);
        if (i == 3) push(sum);
        op(ra, 1, rb, 1);
      end
    end

    cyc(); cyc();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/smart_mac_router.md
Name: smart_mac_router

Overview:
- Parametrised successor of the single-lane smart MAC PE.
- Signed MAC with registered systolic pass-through, plus multi-lane horizontal and vertical smart buses carrying per-lane valid bits.
- Either operand can be sourced from any bus lane. A finished accumulation can be inserted, saturated, onto one chosen lane per direction.
- An accumulation-length counter turns the PE into an output-stationary reduction unit. Routing and length are set by a latched config.

Parameters:
- WORD_SIZE, 16, operand/bus data width (signed two's complement)
- LANES, 2, smart-bus lanes per direction (>=1)
- ACC_SIZE, 40, accumulator/result width (>= 2*WORD_SIZE)
- CNT_W, 8, accumulation-length counter width
- Local: SEL_W = $clog2(LANES+1); LIDX_W = max(1, $clog2(LANES)); LW = WORD_SIZE+1 (lane = {valid, data})

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- cfg_load_in  in  1  latch cfg_* fields
- cfg_src_left_in  in  SEL_W  0 = left_in; k = h-lane k-1
- cfg_src_top_in  in  SEL_W  0 = top_in; k = v-lane k-1
- cfg_h_ins_en_in  in  1  insert result on horizontal bus
- cfg_h_ins_lane_in  in  LIDX_W  horizontal insertion lane
- cfg_v_ins_en_in  in  1  insert result on vertical bus
- cfg_v_ins_lane_in  in  LIDX_W  vertical insertion lane
- cfg_acc_len_in  in  CNT_W  products per result (0 treated as 1)
- cfg_busy_out  out  1  high in ACC state; cfg loads ignored
- left_in / top_in  in  WORD_SIZE  local operands
- left_valid_in / top_valid_in  in  1  local operand valids
- right_out / bottom_out  out  WORD_SIZE  registered selected operands
- right_valid_out / bottom_valid_out  out  1  their valids
- horizontal_smart_bus_in  in  LANES*LW  lane k at [k*LW +: LW], MSB = valid
- horizontal_smart_bus_out  out  LANES*LW
- vertical_smart_bus_in  in  LANES*LW
- vertical_smart_bus_out  out  LANES*LW
- result_out  out  ACC_SIZE  finished accumulation
- result_valid_out  out  1  one-cycle pulse

Behaviour:
- Reset (rst==0 at posedge): acc, count, result_out, right/bottom outputs and all valids are 0. Config resets to src=0, inserts disabled, acc_len=1. FSM enters IDLE.
- Operand a = src_left==0 ? {left_valid_in, left_in} : h-lane src_left-1. Operand b likewise from top / v-lane. A select value > LANES selects local.
- Pass-through: right_out/right_valid_out <= a each cycle (latency 1). bottom likewise <= b. Not gated by FSM.
- fire = a.valid & b.valid. prod = signed a*b, sign-extended to ACC_SIZE. acc wraps modulo 2^ACC_SIZE.
- FSM:
  - IDLE (count==0): cfg_load_in latches config.
    - fire with eff_len==1: result_out <= prod, valid pulse, stay IDLE.
    - fire otherwise: acc <= prod, count <= 1, go to ACC.
  - ACC: cfg_load_in ignored; cfg_busy_out=1.
    - fire and count+1==eff_len: result_out <= acc+prod, result_valid_out=1 next cycle, acc/count <= 0, go to IDLE.
    - fire otherwise: acc += prod, count++.
    - No fire: hold.
- cfg_load_in and fire in the same IDLE cycle: the new config takes effect next cycle. The current fire uses the old config, including its acc_len.
- Bus outputs (combinational): every lane passes in→out. Exception: if h_ins_en, lane h_ins_lane out = {result_valid_out, sat_W(result_out)}. The vertical bus follows the same rule.
  - The inserted lane's incoming value is dropped.
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
- Insertion lane index >= LANES: no insertion; all lanes pass through.
- Reset mid-accumulation discards the partial sum; no result pulse is produced.

Optional Feature:
- SMART_BUS_PIPE_EN defined: both bus outputs are registered (1-cycle hop latency; lane valid/data reset to 0). Insertion is applied before the register.
- SMART_BUS_PIPE_EN undefined: buses are purely combinational, as described above.

Test Plan:
- Reset, then acc_len=1, local sources, left=3, top=-4, both valid → next cycle result_out=-12 with a one-cycle result_valid_out; right_out=3, bottom_out=-4.
- acc_len=3, pairs (2,5),(1,1),(-3,2) with an invalid gap cycle → one pulse only, after the 3rd fire, result=5. cfg_busy_out=1 between fires. A cfg_load_in during ACC leaves config unchanged.
- LANES=2, src_left=2, src_top=1; h-lane1={1,7}, v-lane0={1,6}, local inputs invalid → result 42, right_out=7.
- h_ins_en, lane 0, WORD_SIZE=16, products 300*300 → lane0 out = {1,16'h7FFF} for one cycle; lane1 passes unchanged. Product -300*300 → 16'h8000.
- rst=0 asserted in ACC after 2 of 4 fires, then 4 new fires of (1,1) → result=4 (old partial discarded).
- With SMART_BUS_PIPE_EN: bus lane change appears at the output one cycle later; without it, the change appears in the same cycle.
